// File: rtl/mad_check_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mad_check_pkg : shared types and helpers for the MAD result checker  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package mad_check_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 64;
  localparam int c_CNT_W              = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mad_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
    return (&v) ? v : v + c_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mad_check_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mad_check_fifo : show-ahead synchronous FIFO for expected results    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module mad_check_fifo
  import mad_check_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic                  MCLK,
  input  logic                  nRST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]         r_wr_ptr;
  logic [c_AW:0]         r_rd_ptr;
  logic                  w_wr;
  logic                  w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);
  assign dout = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (w_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/mad_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mad_result_checker : golden A*B+C scoreboard for the MAD unit family |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module mad_result_checker
  import mad_check_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  MCLK,
  input  logic                  nRST,
  input  logic                  IE,
  input  logic                  IREADY,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic                  OE,
  input  logic [DATA_WIDTH-1:0] O,
  input  logic                  FINISH,
  output logic                  DONE,
  output logic                  PASS,
  output logic [c_CNT_W-1:0]    MATCH_COUNT,
  output logic [c_CNT_W-1:0]    ERROR_COUNT,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_EXP,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_GOT,
  output logic                  OVERFLOW,
  output logic                  UNEXPECTED,
  output logic                  TIMEOUT
);

  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  mad_state_e            r_state;
  mad_state_e            w_state_nxt;
  logic [c_TO_W-1:0]     r_to_cnt;
  logic [c_TO_W-1:0]     w_to_nxt;
  logic                  w_timeout_ev;

  logic [c_CNT_W-1:0]    r_match_cnt;
  logic [c_CNT_W-1:0]    r_err_cnt;
  logic [DATA_WIDTH-1:0] r_first_exp;
  logic [DATA_WIDTH-1:0] r_first_got;
  logic                  r_overflow;
  logic                  r_unexpected;
  logic                  r_timeout;
  logic                  r_done;
  logic                  r_pass;

  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_exp;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_bypass;
  logic                  w_overflow_ev;
  logic                  w_unexp_ev;
  logic                  w_cmp_ev;
  logic [DATA_WIDTH-1:0] w_cmp_exp;
  logic                  w_match_ev;
  logic                  w_mismatch_ev;
  logic                  w_err_ev;

  logic [c_CNT_W-1:0]    w_match_nxt;
  logic [c_CNT_W-1:0]    w_err_nxt;
  logic                  w_overflow_nxt;
  logic                  w_unexp_nxt;
  logic                  w_timeout_nxt;
  logic                  w_pass_nxt;

  // Golden model: product and sum both wrap modulo 2^DATA_WIDTH.
  assign w_push = IE && IREADY;
  assign w_prod = A * B;
  assign w_exp  = w_prod + C;

  // A result arriving alongside its own issue on an empty queue never touches the FIFO.
  assign w_bypass      = w_fifo_empty && w_push && OE;
  assign w_fifo_pop    = OE && !w_fifo_empty;
  assign w_fifo_push   = w_push && !w_bypass && (!w_fifo_full || OE);
  assign w_overflow_ev = w_push && w_fifo_full && !OE;
  assign w_unexp_ev    = OE && w_fifo_empty && !w_push;

  assign w_cmp_ev      = OE && !w_unexp_ev;
  assign w_cmp_exp     = w_fifo_empty ? w_exp : w_fifo_head;
  assign w_match_ev    = w_cmp_ev && (O == w_cmp_exp);
  assign w_mismatch_ev = w_cmp_ev && (O != w_cmp_exp);
  assign w_err_ev      = w_mismatch_ev || w_overflow_ev || w_unexp_ev;

  mad_check_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .MCLK  (MCLK),
    .nRST  (nRST),
    .push  (w_fifo_push),
    .pop   (w_fifo_pop),
    .din   (w_exp),
    .dout  (w_fifo_head),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_to_nxt     = '0;
    w_timeout_ev = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (FINISH)      w_state_nxt = w_push ? ST_DRAIN : ST_DONE;
        else if (w_push) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (FINISH) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A new push keeps the drain alive even if the queue just emptied.
        if (w_fifo_empty && !w_push) begin
          w_state_nxt = ST_DONE;
        end else if (!OE) begin
          if (r_to_cnt == c_TO_LAST) begin
            w_timeout_ev = 1'b1;
            w_state_nxt  = ST_DONE;
          end else begin
            w_to_nxt = r_to_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_DONE;
      end
    endcase
  end

  assign w_match_nxt    = w_match_ev ? sat_inc(r_match_cnt) : r_match_cnt;
  assign w_err_nxt      = w_err_ev   ? sat_inc(r_err_cnt)   : r_err_cnt;
  assign w_overflow_nxt = r_overflow   || w_overflow_ev;
  assign w_unexp_nxt    = r_unexpected || w_unexp_ev;
  assign w_timeout_nxt  = r_timeout    || w_timeout_ev;
  assign w_pass_nxt     = (w_state_nxt == ST_DONE) && (w_err_nxt == '0) &&
                          !w_overflow_nxt && !w_unexp_nxt && !w_timeout_nxt;

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_IDLE;
      r_to_cnt     <= '0;
      r_match_cnt  <= '0;
      r_err_cnt    <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_overflow   <= 1'b0;
      r_unexpected <= 1'b0;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_to_cnt     <= w_to_nxt;
      r_match_cnt  <= w_match_nxt;
      r_err_cnt    <= w_err_nxt;
      r_overflow   <= w_overflow_nxt;
      r_unexpected <= w_unexp_nxt;
      r_timeout    <= w_timeout_nxt;
      r_done       <= (w_state_nxt == ST_DONE);
      r_pass       <= w_pass_nxt;
      // Only the very first error of any kind may capture values.
      if (r_err_cnt == '0) begin
        if (w_mismatch_ev) begin
          r_first_exp <= w_cmp_exp;
          r_first_got <= O;
        end else if (w_unexp_ev) begin
          r_first_exp <= '0;
          r_first_got <= O;
        end
      end
    end
  end

  assign DONE          = r_done;
  assign PASS          = r_pass;
  assign MATCH_COUNT   = r_match_cnt;
  assign ERROR_COUNT   = r_err_cnt;
  assign FIRST_ERR_EXP = r_first_exp;
  assign FIRST_ERR_GOT = r_first_got;
  assign OVERFLOW      = r_overflow;
  assign UNEXPECTED    = r_unexpected;
  assign TIMEOUT       = r_timeout;

endmodule
`default_nettype wire

// File: doc/mad_result_checker.md
Name: mad_result_checker

Overview:
- Downstream stage of the MAD family: the hardware scoreboard for MAD, MAD_multicycled, MAD_multicycled_Ex and MAD_multicycled_Slice.
- Snoops each accepted operand issue and computes the golden A*B+C into an in-order expected queue.
- Consumes the unit's OE/O result stream and compares each result against the queue head.
- Reports match/error counts, the first mismatch, protocol faults and a final PASS/DONE, so top-level DUTs self-check instead of relying on waveform inspection.

Parameters:
- DATA_WIDTH, 64, operand and result width.
- DEPTH, 16, expected-queue entries (power of two, >=2).
- TIMEOUT_CYCLES, 256, maximum number of cycles in DRAIN without an OE before TIMEOUT.

Ports:
- MCLK  in  1  clock; one clock domain.
- nRST  in  1  reset; asynchronous, active-low.
- IE  in  1  operand issue strobe, same net that drives the MAD unit.
- IREADY  in  1  MAD ready; an issue is accepted when IE && IREADY.
- A, B, C  in  DATA_WIDTH each  issued operands.
- OE  in  1  MAD result valid.
- O  in  DATA_WIDTH  MAD result.
- FINISH  in  1  single-cycle pulse: no further issues will follow; start draining.
- DONE  out  1  sticky; checking finished.
- PASS  out  1  DONE && ERROR_COUNT==0 && !OVERFLOW && !UNEXPECTED && !TIMEOUT.
- MATCH_COUNT  out  32  results that compared equal.
- ERROR_COUNT  out  32  mismatches + overflow drops + unexpected results.
- FIRST_ERR_EXP  out  DATA_WIDTH  expected value of the first mismatch.
- FIRST_ERR_GOT  out  DATA_WIDTH  received value of the first mismatch.
- OVERFLOW  out  1  sticky; a push was attempted while the queue was full.
- UNEXPECTED  out  1  sticky; OE arrived with nothing expected.
- TIMEOUT  out  1  sticky; DRAIN exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (async, nRST low): all outputs are 0, the queue is empty, FSM is IDLE, and the timeout counter is 0. Asserting reset mid-run discards the queue and all counters immediately.
- Push: on IE && IREADY, exp = (A*B + C) truncated to the low DATA_WIDTH bits (modulo 2^DATA_WIDTH). It is computed combinationally and written at the same edge.
- Pop: on OE, compare O with the queue head, then pop.
  - Equal: MATCH_COUNT++.
  - Not equal: ERROR_COUNT++. If this is the first error, latch FIRST_ERR_EXP/FIRST_ERR_GOT.
- Bypass: if the queue is empty and push and OE occur in the same cycle, compare O against the freshly computed exp directly; no queue write happens. This supports a zero-latency combinational MAD.
- Simultaneous push+pop on a non-empty queue: the occupancy count is unchanged. A push while full with a simultaneous pop is legal.
- Push while full with no pop: the entry is dropped, OVERFLOW=1, ERROR_COUNT++.
- OE with an empty queue and no push: UNEXPECTED=1, ERROR_COUNT++. FIRST_ERR_EXP=0 and FIRST_ERR_GOT=O if this is the first error.
- Counters saturate at 32'hFFFF_FFFF.
- FSM states and transitions:
  - IDLE → RUN on the first push.
  - IDLE → DONE on FINISH (zero transactions gives PASS=1).
  - RUN → DRAIN on FINISH.
  - DRAIN → DONE when the queue is empty (next cycle after the last pop).
  - DRAIN: the timeout counter increments each cycle without OE and clears on OE. Reaching TIMEOUT_CYCLES sets TIMEOUT=1 and goes to DONE.
  - DONE is terminal until reset. Pushes and pops are still checked and counted in DONE, but DONE never deasserts.
- FINISH in RUN with an empty queue: go to DRAIN, then DONE next cycle. FINISH in DRAIN or DONE is ignored. Pushes during DRAIN are accepted and extend the drain.
- Latency: count and flag updates are visible 1 cycle after the triggering edge. DONE and PASS are registered.

Decomposition:
- Package mad_check_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the default DATA_WIDTH;
  - the counter width (32) and the saturating-increment function.
- Sub-module mad_check_fifo: synchronous FIFO.
  - Parameters: DEPTH, DATA_WIDTH.
  - Signals: push, pop, din, dout (head, show-ahead), empty, full.
  - Pointer wrap uses an extra MSB.
- Top level holds the golden compute, the bypass/compare logic, counters and the FSM.

Test Plan:
- Nine back-to-back issues (3,4,5)…(19,20,21) into a 3-cycle MAD model, then FINISH → MATCH_COUNT=9, ERROR_COUNT=0, DONE=1, PASS=1.
- Same stimulus against a zero-latency combinational model (OE=IE) → bypass path; MATCH_COUNT=9, PASS=1, OVERFLOW=0.
- Model corrupts the 2nd result to 38 (expected 37) → ERROR_COUNT=1, FIRST_ERR_EXP=37, FIRST_ERR_GOT=38, PASS=0.
- DEPTH=16; 17 issues with outputs stalled → OVERFLOW=1, ERROR_COUNT=1; after release, 16 matches.
- OE pulse with no prior issue → UNEXPECTED=1, ERROR_COUNT=1, FIRST_ERR_GOT=O.
- Issue 2 ops, return 1, FINISH, never return the 2nd → TIMEOUT=1 exactly 256 cycles into DRAIN, DONE=1, PASS=0. Reset mid-DRAIN → all outputs 0, state IDLE.
